// File: rtl/axil_read_master_q.sv
// AXI-Lite read master with a request FIFO, registered AR channel and up to
// MAX_OUT reads in flight; each R beat is returned to the module with an error flag.
module axil_read_master_q #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUT    = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  MOD_2_M_RRQST,
  input  logic [ADDR_WIDTH-1:0] MOD_2_M_RADDR,
  output logic                  M_2_MOD_RACK,
  output logic [DATA_WIDTH-1:0] M_2_MOD_RDATA,
  output logic                  M_2_MOD_RVALID,
  output logic                  M_2_MOD_RERR,
  output logic [3:0]            OUTSTANDING,
  output logic [7:0]            ERR_CNT,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam int             PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE   = 1;
  localparam logic [3:0]     MAX_OUT_L = 4'(MAX_OUT);

  logic [ADDR_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [3:0]            outst_q, outst_d;
  logic                  rready_q, rready_d;
  logic                  mod_rvalid_q, mod_rvalid_d;
  logic [DATA_WIDTH-1:0] mod_rdata_q, mod_rdata_d;
  logic                  mod_rerr_q, mod_rerr_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic fifo_empty, fifo_full;
  logic push, pop, r_hs;
  logic unused_rresp;

  // Only RRESP[1] separates OKAY/EXOKAY from SLVERR/DECERR.
  assign unused_rresp = RRESP[0];

  // Extra wrap bit: equal pointers mean empty, differing only in the wrap bit means full.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign push = MOD_2_M_RRQST && !fifo_full;
  assign pop  = !fifo_empty && (!arvalid_q || ARREADY) && (outst_q < MAX_OUT_L);
  assign r_hs = RVALID && rready_q;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    outst_d      = outst_q;
    mod_rvalid_d = 1'b0;
    mod_rdata_d  = mod_rdata_q;
    mod_rerr_d   = mod_rerr_q;
    err_cnt_d    = err_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      arvalid_d = 1'b1;
      araddr_d  = mem_q[rd_ptr_q[PTR_W-1:0]];
    end else if (ARREADY) begin
      arvalid_d = 1'b0;
    end

    case ({pop, r_hs})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase

    if (r_hs) begin
      mod_rvalid_d = 1'b1;
      mod_rdata_d  = RDATA;
      mod_rerr_d   = RRESP[1];
      if (RRESP[1] && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  // RREADY tracks the updated count so it is already high when the first beat can arrive.
  assign rready_d = (outst_d != 4'd0);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!ARESETN) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      outst_q      <= 4'd0;
      rready_q     <= 1'b0;
      mod_rvalid_q <= 1'b0;
      mod_rdata_q  <= '0;
      mod_rerr_q   <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      outst_q      <= outst_d;
      rready_q     <= rready_d;
      mod_rvalid_q <= mod_rvalid_d;
      mod_rdata_q  <= mod_rdata_d;
      mod_rerr_q   <= mod_rerr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= MOD_2_M_RADDR;
    end
  end

  assign M_2_MOD_RACK   = !fifo_full;
  assign M_2_MOD_RDATA  = mod_rdata_q;
  assign M_2_MOD_RVALID = mod_rvalid_q;
  assign M_2_MOD_RERR   = mod_rerr_q;
  assign OUTSTANDING    = outst_q;
  assign ERR_CNT        = err_cnt_q;
  assign ARADDR         = araddr_q;
  assign ARVALID        = arvalid_q;
  assign RREADY         = rready_q;

endmodule

// File: tb/tb_axil_read_master_q.sv
// Self-checking bench for axil_read_master_q: directed scenarios plus randomized
// traffic checked against a queue-based transaction model and a reactive slave.
module tb_axil_read_master_q;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int MO    = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          rrqst = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rvalid = 1'b0;

  logic          M_2_MOD_RACK, M_2_MOD_RVALID, M_2_MOD_RERR;
  logic [DW-1:0] M_2_MOD_RDATA;
  logic [3:0]    OUTSTANDING;
  logic [7:0]    ERR_CNT;
  logic [AW-1:0] ARADDR;
  logic          ARVALID, RREADY;

  axil_read_master_q #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_OUT(MO)
  ) dut (
    .ACLK(aclk), .ARESETN(aresetn),
    .MOD_2_M_RRQST(rrqst), .MOD_2_M_RADDR(raddr), .M_2_MOD_RACK(M_2_MOD_RACK),
    .M_2_MOD_RDATA(M_2_MOD_RDATA), .M_2_MOD_RVALID(M_2_MOD_RVALID), .M_2_MOD_RERR(M_2_MOD_RERR),
    .OUTSTANDING(OUTSTANDING), .ERR_CNT(ERR_CNT),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(arready),
    .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(RREADY)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } slv_t;

  // Transaction-level model state
  logic [AW-1:0] req_q[$];    // requests the module still wants to push
  logic [AW-1:0] exp_ar[$];   // accepted requests not yet seen on AR, in order
  slv_t          slv_q[$];    // reads the slave has accepted, answered in order
  logic [DW-1:0] data_q[$];   // forced read data for the next slave beats
  logic [1:0]    resp_q[$];   // forced responses for the next slave beats
  logic          err_obs_q[$];
  logic [DW-1:0] last_ret_data;
  int            exp_err_cnt;

  int checks = 0, failures = 0, cyc = 0;
  int req_pct = 100, ar_pct = 100, dly_min = 0, dly_max = 0, err_pct = 0;
  int n_acc = 0, n_ar_hs = 0, n_r_hs = 0;
  bit last_acc, last_ar_hs, last_r_hs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_arvalid"}, ARVALID, 0);
    check({tag, "_araddr"}, ARADDR, 0);
    check({tag, "_rready"}, RREADY, 0);
    check({tag, "_mod_rvalid"}, M_2_MOD_RVALID, 0);
    check({tag, "_mod_rdata"}, M_2_MOD_RDATA, 0);
    check({tag, "_mod_rerr"}, M_2_MOD_RERR, 0);
    check({tag, "_outstanding"}, OUTSTANDING, 0);
    check({tag, "_err_cnt"}, ERR_CNT, 0);
    check({tag, "_rack"}, M_2_MOD_RACK, 1);
  endtask

  task automatic clear_model();
    req_q.delete(); exp_ar.delete(); slv_q.delete();
    data_q.delete(); resp_q.delete();
    exp_err_cnt = 0;
    last_ret_data = '0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0; rrqst = 1'b0; rvalid = 1'b0; arready = 1'b0;
    #1;
    check_reset_vals("rst_async");
    clear_model();
    repeat (2) @(negedge aclk);
    check_reset_vals("rst_hold");
    aresetn = 1'b1;
  endtask

  // One clock: drive module/slave inputs, predict handshakes, then check outputs.
  task automatic cycle();
    logic          pre_arvalid, pre_arready;
    logic [AW-1:0] pre_araddr;
    logic [DW-1:0] ret_data;
    logic          ret_err;
    int            fifo_cnt, exp_out;
    slv_t          ent;

    @(negedge aclk);
    if (req_q.size() > 0 && $urandom_range(99) < req_pct) begin
      rrqst = 1'b1; raddr = req_q[0];
    end else begin
      rrqst = 1'b0; raddr = $urandom;
    end
    arready = ($urandom_range(99) < ar_pct);
    if (slv_q.size() > 0 && slv_q[0].due <= cyc) begin
      rvalid = 1'b1; rdata = slv_q[0].data; rresp = slv_q[0].resp;
    end else begin
      rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
    end
    #1;

    fifo_cnt = exp_ar.size() - ((ARVALID === 1'b1) ? 1 : 0);
    check("rack", M_2_MOD_RACK, fifo_cnt < DEPTH);

    last_acc    = rrqst && M_2_MOD_RACK;
    last_ar_hs  = ARVALID && arready;
    last_r_hs   = rvalid && RREADY;
    pre_arvalid = ARVALID;
    pre_arready = arready;
    pre_araddr  = ARADDR;
    ret_data    = '0;
    ret_err     = 1'b0;

    if (last_ar_hs) begin
      check("ar_expected", exp_ar.size() != 0, 1);
      if (exp_ar.size() != 0) begin
        check("araddr_order", ARADDR, exp_ar[0]);
        void'(exp_ar.pop_front());
      end
      ent.addr = ARADDR;
      ent.due  = cyc + 1 + int'($urandom_range(dly_max, dly_min));
      ent.data = (data_q.size() > 0) ? data_q.pop_front() : DW'($urandom);
      if (resp_q.size() > 0) ent.resp = resp_q.pop_front();
      else                   ent.resp = {($urandom_range(99) < err_pct), 1'($urandom)};
      slv_q.push_back(ent);
      n_ar_hs++;
    end
    if (last_r_hs) begin
      ret_data = slv_q[0].data;
      ret_err  = slv_q[0].resp[1];
      void'(slv_q.pop_front());
      if (ret_err && exp_err_cnt < 255) exp_err_cnt++;
      n_r_hs++;
    end
    if (last_acc) begin
      exp_ar.push_back(raddr);
      void'(req_q.pop_front());
      n_acc++;
    end

    @(posedge aclk);
    #1;
    cyc++;

    check("mod_rvalid", M_2_MOD_RVALID, last_r_hs);
    if (last_r_hs) begin
      check("mod_rdata", M_2_MOD_RDATA, ret_data);
      check("mod_rerr", M_2_MOD_RERR, ret_err);
      err_obs_q.push_back(M_2_MOD_RERR);
      last_ret_data = ret_data;
    end else begin
      check("mod_rdata_hold", M_2_MOD_RDATA, last_ret_data);
    end
    check("err_cnt", ERR_CNT, exp_err_cnt);
    exp_out = ((ARVALID === 1'b1) ? 1 : 0) + slv_q.size();
    check("outstanding", OUTSTANDING, exp_out);
    check("outstanding_le_max", OUTSTANDING <= MO, 1);
    check("rready", RREADY, exp_out != 0);
    if (pre_arvalid && !pre_arready) begin
      check("arvalid_hold", ARVALID, 1);
      check("araddr_hold", ARADDR, pre_araddr);
    end
  endtask

  task automatic drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (req_q.size() == 0 && exp_ar.size() == 0 && slv_q.size() == 0) break;
      cycle();
    end
    check({tag, "_drained"}, (req_q.size() == 0 && exp_ar.size() == 0 && slv_q.size() == 0), 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc, base_ar, base_r, ar_before, waited;

    // Reset then idle
    clear_model();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("idle_arvalid", ARVALID, 0);
      check("idle_rack", M_2_MOD_RACK, 1);
    end

    // Single read of 0x0A returning 0xDEADBEEF
    ar_pct = 100; dly_min = 3; dly_max = 3; err_pct = 0;
    data_q.push_back(32'hDEADBEEF);
    resp_q.push_back(2'b00);
    req_q.push_back(32'h0000_000A);
    cycle();
    check("single_accepted", last_acc, 1);
    check("single_arvalid_n", ARVALID, 0);
    check("single_out_n", OUTSTANDING, 0);
    cycle();
    check("single_arvalid_n1", ARVALID, 1);
    check("single_araddr", ARADDR, 32'h0000_000A);
    check("single_out_n1", OUTSTANDING, 1);
    cycle();
    check("single_ar_hs", last_ar_hs, 1);
    check("single_arvalid_drop", ARVALID, 0);
    check("single_out_wait", OUTSTANDING, 1);
    waited = 0;
    while (!last_r_hs && waited < 12) begin
      cycle();
      waited++;
    end
    check("single_r_seen", last_r_hs, 1);
    check("single_pulse", M_2_MOD_RVALID, 1);
    check("single_rdata", M_2_MOD_RDATA, 32'hDEADBEEF);
    check("single_rerr", M_2_MOD_RERR, 0);
    check("single_out_back", OUTSTANDING, 0);
    cycle();
    check("single_pulse_end", M_2_MOD_RVALID, 0);

    // Six back-to-back requests with the address channel stalled
    base_acc = n_acc; base_r = n_r_hs;
    ar_pct = 0;
    for (int i = 1; i <= 6; i++) req_q.push_back(AW'(i * 16));
    repeat (8) cycle();
    check("stall_accepted", n_acc - base_acc, 5);
    check("stall_rack_low", M_2_MOD_RACK, 0);
    check("stall_arvalid", ARVALID, 1);
    check("stall_araddr", ARADDR, 32'h10);
    check("stall_left", req_q.size(), 1);
    ar_pct = 100; dly_min = 0; dly_max = 3;
    drain("stall", 300);
    check("stall_returns", n_r_hs - base_r, 6);

    // Outstanding limit with a slow slave
    base_ar = n_ar_hs; base_r = n_r_hs;
    dly_min = 10; dly_max = 10;
    req_q.push_back(32'h10); req_q.push_back(32'h20); req_q.push_back(32'h30);
    ar_before = -1;
    for (int i = 0; i < 40 && n_r_hs == base_r; i++) begin
      cycle();
      if (last_r_hs) ar_before = n_ar_hs - base_ar;
    end
    check("limit_ar_before_first_r", ar_before, 2);
    for (int i = 0; i < 10 && (n_ar_hs - base_ar) < 3; i++) cycle();
    check("limit_third_issued", n_ar_hs - base_ar, 3);
    drain("limit", 100);
    check("limit_returns", n_r_hs - base_r, 3);

    // Error response on the middle read of three
    dly_min = 0; dly_max = 2;
    err_obs_q.delete();
    resp_q.push_back(2'b00); resp_q.push_back(2'b10); resp_q.push_back(2'b00);
    req_q.push_back(32'h100); req_q.push_back(32'h104); req_q.push_back(32'h108);
    drain("err3", 100);
    check("err3_pulses", err_obs_q.size(), 3);
    if (err_obs_q.size() == 3) begin
      check("err3_first", err_obs_q[0], 0);
      check("err3_second", err_obs_q[1], 1);
      check("err3_third", err_obs_q[2], 0);
    end
    check("err3_cnt", ERR_CNT, 1);

    // Randomized traffic
    base_r = n_r_hs;
    req_pct = 60; ar_pct = 50; dly_min = 0; dly_max = 5; err_pct = 25;
    for (int i = 0; i < 150; i++) req_q.push_back(AW'($urandom));
    drain("random", 5000);
    check("random_returns", n_r_hs - base_r, 150);

    // Error counter saturation
    req_pct = 100; ar_pct = 100; dly_min = 0; dly_max = 1; err_pct = 100;
    for (int i = 0; i < 300; i++) req_q.push_back(AW'($urandom));
    drain("saturate", 5000);
    check("saturate_err_cnt", ERR_CNT, 255);

    // Reset with two reads in flight and three queued
    err_pct = 0; dly_min = 50; dly_max = 50;
    for (int i = 0; i < 5; i++) req_q.push_back(AW'(32'h200 + i * 4));
    for (int i = 0; i < 30; i++) begin
      if (slv_q.size() == 2 && exp_ar.size() == 3 && req_q.size() == 0) break;
      cycle();
    end
    check("midrst_inflight", slv_q.size(), 2);
    check("midrst_queued", exp_ar.size(), 3);
    check("midrst_outstanding", OUTSTANDING, 2);
    @(negedge aclk);
    aresetn = 1'b0; rrqst = 1'b0;
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
    #1;
    check_reset_vals("midrst");
    clear_model();
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      if (i == 2) aresetn = 1'b1;
      #1;
      check("midrst_rready", RREADY, 0);
      check("midrst_mod_rvalid", M_2_MOD_RVALID, 0);
      check("midrst_outstanding_zero", OUTSTANDING, 0);
      check("midrst_arvalid", ARVALID, 0);
    end
    rvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
